// File: rtl/fir_sample_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_sample_scheduler: feeds paired FIR filters at a programmable period,   |
// | captures and cross-checks their results.           Revision: 1.0          |
// +----------------------------------------------------------------------------+
module fir_sample_scheduler #(
  parameter int WIDTH      = 16,
  parameter int PERIOD_W   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LAT        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [PERIOD_W-1:0]        cfg_period,
  input  logic                       err_clr,
  input  logic signed [WIDTH-1:0]    s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic signed [WIDTH-1:0]    fir_sig,
  output logic                       fir_ready,
  input  logic signed [WIDTH-1:0]    fir_out_a,
  input  logic signed [WIDTH-1:0]    fir_out_b,
  output logic signed [WIDTH-1:0]    m_data,
  output logic                       m_valid,
  output logic                       mismatch,
  output logic [7:0]                 mismatch_cnt,
  output logic [7:0]                 underrun_cnt
);

  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = AW + 1;
  localparam int LW       = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam int LAT_LAST = (LAT >= 2) ? LAT - 2 : 0;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STROBE  = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [PERIOD_W-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]           lat_cnt_q, lat_cnt_d;
  logic signed [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic signed [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    s_ready_q, s_ready_d;
  logic signed [WIDTH-1:0] fir_sig_q, fir_sig_d, m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d, mismatch_q, mismatch_d;
  logic [7:0]              mismatch_cnt_q, mismatch_cnt_d;
  logic [7:0]              underrun_cnt_q, underrun_cnt_d;

  logic tick, push, pop, empty, full, underrun_evt, neq_evt;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign tick  = enable && (cnt_q >= cfg_period);
  assign push  = s_valid && s_ready_q;
  assign pop   = (state_q == S_IDLE) && tick && !empty;
  assign underrun_evt = (state_q == S_IDLE) && tick && empty;
  assign neq_evt      = (state_q == S_CAPTURE) && (fir_out_a != fir_out_b);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (tick && !empty) state_d = S_STROBE;
      S_STROBE:  state_d = (LAT > 1) ? S_SETTLE : S_CAPTURE;
      S_SETTLE:  if (lat_cnt_q == LW'(LAT_LAST)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fir_ready = (state_q == S_STROBE);
  end

  always_comb begin
    cnt_d     = enable ? (tick ? '0 : cnt_q + PERIOD_W'(1)) : '0;
    lat_cnt_d = (state_q == S_SETTLE) ? lat_cnt_q + LW'(1) : '0;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Registered so that s_ready stays low throughout reset.
    s_ready_d = (count_d != CW'(FIFO_DEPTH));

    fir_sig_d = pop ? mem_q[rd_ptr_q] : fir_sig_q;
    m_valid_d = (state_q == S_CAPTURE);
    m_data_d  = (state_q == S_CAPTURE) ? fir_out_a : m_data_q;

    mismatch_d     = mismatch_q;
    mismatch_cnt_d = mismatch_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    if (err_clr) begin
      mismatch_d     = 1'b0;
      mismatch_cnt_d = '0;
      underrun_cnt_d = '0;
    end else begin
      if (neq_evt) begin
        mismatch_d = 1'b1;
        if (mismatch_cnt_q != 8'hFF) mismatch_cnt_d = mismatch_cnt_q + 8'd1;
      end
      if (underrun_evt && underrun_cnt_q != 8'hFF)
        underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      lat_cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      s_ready_q      <= 1'b0;
      fir_sig_q      <= '0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      mismatch_q     <= 1'b0;
      mismatch_cnt_q <= '0;
      underrun_cnt_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      s_ready_q      <= s_ready_d;
      fir_sig_q      <= fir_sig_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      mismatch_q     <= mismatch_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign fir_sig      = fir_sig_q;
  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign mismatch     = mismatch_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_sample_scheduler: directed checks of scheduling, FIFO and errors.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_sample_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [7:0]         cfg_period = 8'd0;
  logic               err_clr = 1'b0;
  logic signed [15:0] s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] fir_sig;
  logic               fir_ready;
  logic signed [15:0] fir_out_a, fir_out_b;
  logic signed [15:0] m_data;
  logic               m_valid, mismatch;
  logic [7:0]         mismatch_cnt, underrun_cnt;

  // Stand-in filters: a = sample+1; b disagrees only for sample 20.
  assign fir_out_a = fir_sig + 16'sd1;
  assign fir_out_b = fir_out_a + ((fir_sig == 16'sd20) ? 16'sd1 : 16'sd0);

  fir_sample_scheduler #(.WIDTH(16), .PERIOD_W(8), .FIFO_DEPTH(4), .LAT(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_period(cfg_period), .err_clr(err_clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fir_sig(fir_sig), .fir_ready(fir_ready), .fir_out_a(fir_out_a), .fir_out_b(fir_out_b),
    .m_data(m_data), .m_valid(m_valid), .mismatch(mismatch),
    .mismatch_cnt(mismatch_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int st_cyc[$], st_sig[$], mv_cyc[$], mv_dat[$], mv_mis[$], mv_cnt[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    st_cyc.delete(); st_sig.delete();
    mv_cyc.delete(); mv_dat.delete(); mv_mis.delete(); mv_cnt.delete();
  endtask

  // Advance n cycles, logging strobes and outputs with cycle index 1..n.
  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (fir_ready) begin st_cyc.push_back(k); st_sig.push_back(int'(fir_sig)); end
      if (m_valid) begin
        mv_cyc.push_back(k); mv_dat.push_back(int'(m_data));
        mv_mis.push_back(int'(mismatch)); mv_cnt.push_back(int'(mismatch_cnt));
      end
    end
  endtask

  task automatic push(input logic signed [15:0] d);
    s_data = d; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int acc;
    int exp_sig[3];
    int exp_bp[4];
    exp_sig = '{100, -200, 300};
    exp_bp  = '{1, 2, 3, 4};

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_fir_sig", int'(fir_sig), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    rst = 1'b0;
    chk("rel_s_ready0", int'(s_ready), 0);
    @(negedge clk);
    chk("rel_s_ready1", int'(s_ready), 1);
    clear_log();
    run(10);
    chk("idle_strobes", st_cyc.size(), 0);
    chk("idle_underrun", int'(underrun_cnt), 0);

    // Basic sequence, period 10
    cfg_period = 8'd9;
    push(100); push(-200); push(300);
    clear_log();
    enable = 1'b1;
    run(45);
    enable = 1'b0;
    chk("basic_n_strobe", st_cyc.size(), 3);
    chk("basic_n_valid", mv_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < st_cyc.size()) begin
        chk("basic_strobe_cyc", st_cyc[i], 10 + 10 * i);
        chk("basic_fir_sig", st_sig[i], exp_sig[i]);
      end
      if (i < mv_cyc.size()) begin
        chk("basic_mvalid_cyc", mv_cyc[i], 13 + 10 * i);
        chk("basic_m_data", mv_dat[i], exp_sig[i] + 1);
        chk("basic_mismatch", mv_mis[i], 0);
      end
    end
    chk("basic_fir_sig_hold", int'(fir_sig), 300);
    chk("basic_underrun", int'(underrun_cnt), 1);
    pulse_clr();
    chk("basic_clr_underrun", int'(underrun_cnt), 0);

    // Backpressure: 6 offered, 4 accepted
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      s_data = 16'(i + 1); s_valid = 1'b1;
      if (s_ready) acc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_s_ready_full", int'(s_ready), 0);
    clear_log();
    enable = 1'b1;
    run(55);
    enable = 1'b0;
    chk("bp_n_strobe", st_cyc.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < st_sig.size()) chk("bp_fir_sig", st_sig[i], exp_bp[i]);
    chk("bp_underrun", int'(underrun_cnt), 1);
    chk("bp_s_ready_drained", int'(s_ready), 1);
    pulse_clr();

    // Mismatch on second sample
    push(10); push(20);
    clear_log();
    enable = 1'b1;
    run(28);
    enable = 1'b0;
    chk("mm_n_valid", mv_cyc.size(), 2);
    if (mv_cyc.size() == 2) begin
      chk("mm_first_flag", mv_mis[0], 0);
      chk("mm_second_flag", mv_mis[1], 1);
      chk("mm_second_cnt", mv_cnt[1], 1);
      chk("mm_second_data", mv_dat[1], 21);
    end
    run(3);
    chk("mm_sticky", int'(mismatch), 1);
    pulse_clr();
    chk("mm_clr_flag", int'(mismatch), 0);
    chk("mm_clr_cnt", int'(mismatch_cnt), 0);

    // Short period: strobes every LAT+2 cycles
    cfg_period = 8'd0;
    push(5); push(6); push(7); push(8);
    clear_log();
    enable = 1'b1;
    run(18);
    enable = 1'b0;
    chk("sp_n_strobe", st_cyc.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < st_cyc.size()) chk("sp_strobe_cyc", st_cyc[i], 1 + 4 * i);
    chk("sp_n_valid", mv_cyc.size(), 4);
    if (mv_cyc.size() > 0) chk("sp_first_mvalid", mv_cyc[0], 4);
    chk("sp_underrun", int'(underrun_cnt), 2);
    pulse_clr();

    // Async reset during SETTLE
    cfg_period = 8'd9;
    push(70); push(80);
    clear_log();
    enable = 1'b1;
    run(11);
    chk("ar_strobe_seen", st_cyc.size(), 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_fir_sig", int'(fir_sig), 0);
    chk("ar_m_data", int'(m_data), 0);
    chk("ar_fir_ready", int'(fir_ready), 0);
    chk("ar_s_ready", int'(s_ready), 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    run(8);
    chk("ar_no_mvalid", mv_cyc.size(), 0);
    chk("ar_no_strobe", st_cyc.size(), 0);
    cfg_period = 8'd0;
    enable = 1'b1;
    run(3);
    enable = 1'b0;
    chk("ar_fifo_empty", st_cyc.size(), 0);
    chk("ar_underrun", int'(underrun_cnt), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_sample_scheduler.md
Name: fir_sample_scheduler

Overview:
- Sequences the paired FIR datapath: the direct-form filter and the separated-form filter, which share one input sample and one `ready` strobe.
- Buffers incoming samples in a small FIFO and issues one sample plus a one-cycle strobe to both filters at a programmable sample period.
- Captures both filter outputs after a fixed latency and forwards the direct-form result downstream.
- Cross-checks the two results and keeps mismatch and underrun statistics.

Parameters:
WIDTH, 16, sample width (matches filter `WIDTH)
PERIOD_W, 8, width of sample-period config
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
LAT, 2, cycles from strobe to valid filter outputs (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  run period counter / scheduler
cfg_period  in  PERIOD_W  sample period minus 1, in clk cycles
err_clr  in  1  synchronous clear of mismatch flag and counters
s_data  in  WIDTH signed  incoming sample
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept
fir_sig  out  WIDTH signed  sample to both filters
fir_ready  out  1  one-cycle strobe to both filters
fir_out_a  in  WIDTH signed  direct-form filter output
fir_out_b  in  WIDTH signed  separated-form filter output
m_data  out  WIDTH signed  captured fir_out_a
m_valid  out  1  one-cycle output valid
mismatch  out  1  sticky: a != b seen at capture
mismatch_cnt  out  8  saturating mismatch count
underrun_cnt  out  8  saturating count of ticks with FIFO empty

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, state IDLE, period counter 0. s_ready becomes 1 on the first cycle after reset deasserts.
- FIFO:
  - s_ready = !full.
  - Push when s_valid & s_ready.
  - Pop only in the IDLE->STROBE transition.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Data written while full is dropped; s_ready=0 already forbids it.
- Period counter:
  - With enable=0: cnt=0 and tick=0.
  - With enable=1: tick=1 when cnt>=cfg_period, then cnt<=0; otherwise cnt<=cnt+1.
  - cfg_period=0 gives a tick every cycle.
  - cfg_period is read live; lowering it below cnt causes a tick on the next cycle.
- FSM: IDLE, STROBE, SETTLE, CAPTURE.
  - IDLE: on tick with FIFO non-empty, pop the head into fir_sig and go to STROBE. On tick with FIFO empty, underrun_cnt++ (saturate at 255) and stay in IDLE.
  - STROBE (cycle t): fir_ready=1 for exactly this cycle; fir_sig holds the popped sample. Go to SETTLE if LAT>1, else CAPTURE.
  - SETTLE: stay LAT-1 cycles (t+1..t+LAT-1), then go to CAPTURE.
  - CAPTURE (cycle t+LAT): register m_data<=fir_out_a and compare fir_out_a with fir_out_b. Go to IDLE.
  - Next cycle (t+LAT+1): m_valid=1 for one cycle. If the compare was unequal, mismatch<=1 and mismatch_cnt++ (saturating).
- fir_sig holds its value until the next STROBE; it is not cleared between samples.
- Ticks arriving in STROBE, SETTLE or CAPTURE are ignored and not counted. Minimum useful period is cfg_period >= LAT+1.
- enable falling mid-sequence: the current sequence completes (m_valid still issued); no new tick arrives.
- err_clr=1 clears mismatch, mismatch_cnt and underrun_cnt on the next edge. If err_clr coincides with a new event, the clear wins.
- m_data and m_valid have no backpressure; the downstream block must accept every m_valid.

Test Plan:
- Reset then idle: rst pulse, enable=0 -> all outputs 0, s_ready=1 one cycle after release, no fir_ready.
- Basic sequence: cfg_period=9, LAT=2, push 100, -200, 300; b tied equal to a -> fir_ready pulses every 10 cycles with fir_sig=100, -200, 300 in order; m_valid 3 cycles after each strobe; mismatch=0.
- Backpressure: push 6 samples back-to-back with enable=0 -> s_ready drops after 4 accepted; then enable -> exactly 4 strobes; cnt-triggered underrun_cnt increments from the 5th tick.
- Mismatch: force fir_out_b=fir_out_a+1 on the 2nd sample -> mismatch=1 in the cycle m_valid is high; mismatch_cnt=1; err_clr -> both 0.
- Short period: cfg_period=0, LAT=2, FIFO full -> a strobe every 4 cycles (STROBE, SETTLE, CAPTURE, IDLE), never two strobes closer than LAT+2.
- Async reset mid-SETTLE: assert rst -> outputs zero immediately without a clock edge; no m_valid after release; FIFO empty.
